// File: rtl/vq_compress_if.sv
// RAM-side bus of the VQ compressor: pixel read (RAM1), codebook read (RAM2), index write (RAM3).
interface vq_compress_if;
  logic [23:0] RAM1_Q;
  logic [19:0] RAM1_A;
  logic        RAM1_OE;
  logic [23:0] RAM2_Q;
  logic [19:0] RAM2_A;
  logic        RAM2_OE;
  logic [23:0] RAM3_D;
  logic [19:0] RAM3_A;
  logic        RAM3_WE;

  modport master (
    input  RAM1_Q, RAM2_Q,
    output RAM1_A, RAM1_OE, RAM2_A, RAM2_OE, RAM3_D, RAM3_A, RAM3_WE
  );

  modport slave (
    output RAM1_Q, RAM2_Q,
    input  RAM1_A, RAM1_OE, RAM2_A, RAM2_OE, RAM3_D, RAM3_A, RAM3_WE
  );
endinterface

// File: rtl/vq_compress.sv
// VQ encoder: loads the codebook, then writes the min-Manhattan-distance index per pixel.
// Optional VQ_EARLY_EXIT_EN: leave SEARCH on the first exact (d==0) match.
module vq_compress #(
  parameter int NUM_PIXELS = 65536,
  parameter int CB_SIZE    = 64
) (
  input  logic             clk,
  input  logic             rst,
  vq_compress_if.master    bus,
  output logic             done
);
  localparam int              KW      = (CB_SIZE > 1) ? $clog2(CB_SIZE) : 1;
  localparam logic [KW-1:0]   K_LAST  = KW'(CB_SIZE - 1);
  localparam logic [KW:0]     LD_LAST = (KW+1)'(CB_SIZE);
  localparam logic [KW:0]     LD_PEN  = (KW+1)'(CB_SIZE - 1);
  localparam logic [19:0]     P_LAST  = 20'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, LATCH, SEARCH, WRITE, FIN} state_t;

  state_t          state;
  logic [23:0]     cb [CB_SIZE];
  logic [23:0]     pix;
  logic [23:0]     cw;
  logic [KW:0]     ld_cnt;
  logic [KW-1:0]   k;
  logic [19:0]     p;
  logic [9:0]      best_dist;
  logic [5:0]      best_idx;
  logic [2:0][7:0] ad;
  logic [9:0]      d;
  logic            exit_now;
  logic            take;
  logic [5:0]      sel_idx;

  assign cw = cb[k];

  for (genvar c = 0; c < 3; c++) begin : g_ad
    logic [7:0] a, b;
    assign a     = pix[8*c +: 8];
    assign b     = cw[8*c +: 8];
    assign ad[c] = (a >= b) ? (a - b) : (b - a);
  end

  // 10-bit sum: 3 x 255 = 765 fits without wrap
  assign d = {2'b0, ad[0]} + {2'b0, ad[1]} + {2'b0, ad[2]};

`ifdef VQ_EARLY_EXIT_EN
  assign exit_now = (d == '0);
`else
  assign exit_now = 1'b0;
`endif

  // strict less-than keeps the lowest index on ties
  assign take    = (d < best_dist) || exit_now;
  assign sel_idx = take ? 6'(k) : best_idx;

  // RAM2_Q in LOAD cycle n belongs to the address issued in cycle n-1
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && ld_cnt != '0)
      cb[KW'(ld_cnt - 1'b1)] <= bus.RAM2_Q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.RAM1_A  <= '0;
      bus.RAM1_OE <= 1'b0;
      bus.RAM2_A  <= '0;
      bus.RAM2_OE <= 1'b0;
      bus.RAM3_A  <= '0;
      bus.RAM3_D  <= '0;
      bus.RAM3_WE <= 1'b0;
      done        <= 1'b0;
      ld_cnt      <= '0;
      k           <= '0;
      p           <= '0;
      pix         <= '0;
      best_dist   <= '1;
      best_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state       <= LOAD;
          bus.RAM2_OE <= 1'b1;
          bus.RAM2_A  <= '0;
          ld_cnt      <= '0;
        end
        LOAD: begin
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_cnt == LD_LAST) begin
            state       <= FETCH;
            p           <= '0;
            bus.RAM1_A  <= '0;
            bus.RAM1_OE <= 1'b1;
          end else if (ld_cnt == LD_PEN) begin
            bus.RAM2_OE <= 1'b0;
          end else begin
            bus.RAM2_A  <= 20'(ld_cnt) + 20'd1;
          end
        end
        FETCH: begin
          bus.RAM1_OE <= 1'b0;
          state       <= LATCH;
        end
        LATCH: begin
          pix       <= bus.RAM1_Q;
          best_dist <= '1;
          best_idx  <= '0;
          k         <= '0;
          state     <= SEARCH;
        end
        SEARCH: begin
          if (take) begin
            best_dist <= d;
            best_idx  <= 6'(k);
          end
          k <= k + 1'b1;
          if (k == K_LAST || exit_now) begin
            state       <= WRITE;
            bus.RAM3_WE <= 1'b1;
            bus.RAM3_A  <= p;
            bus.RAM3_D  <= {18'b0, sel_idx};
          end
        end
        WRITE: begin
          bus.RAM3_WE <= 1'b0;
          if (p == P_LAST) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            p           <= p + 1'b1;
            bus.RAM1_A  <= p + 1'b1;
            bus.RAM1_OE <= 1'b1;
            state       <= FETCH;
          end
        end
        FIN: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vq_compress.sv
// Directed bench for vq_compress: 4-pixel runs against hand-computed indices and cycle counts.
module tb_vq_compress;
  localparam int NP = 4;
  localparam int CB = 64;
`ifdef VQ_EARLY_EXIT_EN
  localparam int EE_CYC = 1 + 65 + 4*9;
`else
  localparam int EE_CYC = 1 + 65 + 4*67;
`endif
  localparam int FULL_CYC = 1 + 65 + 4*67;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done;

  vq_compress_if bus();
  vq_compress #(.NUM_PIXELS(NP), .CB_SIZE(CB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .done(done)
  );

  always #5 clk = ~clk;

  logic [23:0] ram1 [NP];
  logic [23:0] ram2 [CB];
  logic [19:0] wa_q [$];
  logic [23:0] wd_q [$];
  int total = 0;
  int bad   = 0;

  always @(posedge clk) begin
    if (bus.RAM1_OE) bus.RAM1_Q <= ram1[bus.RAM1_A[1:0]];
    if (bus.RAM2_OE) bus.RAM2_Q <= ram2[bus.RAM2_A[5:0]];
  end

  always @(negedge clk) begin
    if (bus.RAM3_WE === 1'b1) begin
      wa_q.push_back(bus.RAM3_A);
      wd_q.push_back(bus.RAM3_D);
    end
  end

  typedef struct {
    int                   mode;
    logic [NP-1:0][23:0]  px;   // px[3] listed first in literals
    logic [NP-1:0][5:0]   idx;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic load_cb(input int mode);
    for (int k = 0; k < CB; k++) begin
      case (mode)
        0:       ram2[k] = {3{8'(4*k)}};
        1:       ram2[k] = (k == 3) ? 24'h000010 : (k == 7) ? 24'h100000 : 24'hFFFFFF;
        2:       ram2[k] = (k == 0) ? 24'h000000 : (k == 1) ? 24'hFFFFFF : 24'h808080;
        default: ram2[k] = (k == 0) ? 24'h000000 : 24'h808080;
      endcase
    end
  endtask

  task automatic load_px(input logic [NP-1:0][23:0] px);
    for (int i = 0; i < NP; i++) ram1[i] = px[i];
  endtask

  task automatic start();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic chk_writes(input string nm, input logic [NP-1:0][5:0] idx);
    chk({nm, "_nwr"}, wa_q.size(), NP);
    for (int i = 0; i < NP; i++) begin
      chk({nm, "_addr"}, 32'(wa_q[i]), i);
      chk({nm, "_idx"}, 32'(wd_q[i]), 32'(idx[i]));
    end
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_a1"}, 32'(bus.RAM1_A), 0);
    chk({nm, "_a2"}, 32'(bus.RAM2_A), 0);
    chk({nm, "_a3"}, 32'(bus.RAM3_A), 0);
    chk({nm, "_d3"}, 32'(bus.RAM3_D), 0);
    chk({nm, "_en"}, {29'b0, bus.RAM1_OE, bus.RAM2_OE, bus.RAM3_WE}, 0);
    chk({nm, "_done"}, 32'(done), 0);
  endtask

  initial begin
    int cyc;
    int n;

    vecs[0].mode = 0;
    vecs[0].px   = {24'h2A2A2A, 24'hFFFFFF, 24'h000000, 24'h282828};
    vecs[0].idx  = {6'd10, 6'd63, 6'd0, 6'd10};
    vecs[1].mode = 1;
    vecs[1].px   = {24'hFFFFFF, 24'h100000, 24'h000010, 24'h080008};
    vecs[1].idx  = {6'd0, 6'd7, 6'd3, 6'd3};
    vecs[2].mode = 2;
    vecs[2].px   = {24'hFE0101, 24'h808080, 24'h000000, 24'hFFFFFF};
    vecs[2].idx  = {6'd0, 6'd2, 6'd0, 6'd1};
    vecs[3].mode = 3;
    vecs[3].px   = {24'hFF0000, 24'h808080, 24'h000000, 24'hFFFFFF};
    vecs[3].idx  = {6'd0, 6'd1, 6'd0, 6'd1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outs("reset");

    for (int v = 0; v < 4; v++) begin
      load_cb(vecs[v].mode);
      load_px(vecs[v].px);
      start();
      wait_done(cyc);
      chk("done_seen", 32'(done), 1);
`ifndef VQ_EARLY_EXIT_EN
      chk("done_cycles", cyc, FULL_CYC);
`endif
      chk_writes("vec", vecs[v].idx);
      repeat (5) @(posedge clk);
      #1;
      chk("done_sticky", 32'(done), 1);
      chk("fin_en", {29'b0, bus.RAM1_OE, bus.RAM2_OE, bus.RAM3_WE}, 0);
    end

    // reset during SEARCH of pixel 2, with new memory contents to prove the reload
    load_cb(0);
    load_px(vecs[0].px);
    start();
    n = 0;
    while (wa_q.size() < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_nwr", wa_q.size(), 2);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    load_cb(1);
    load_px(vecs[1].px);
    @(posedge clk);
    @(negedge clk);
    chk_idle_outs("midrst");
    wa_q.delete();
    wd_q.delete();
    rst = 1'b0;
    wait_done(cyc);
    chk("midrst_done", 32'(done), 1);
    chk("midrst_cycles", cyc, FULL_CYC);
    chk_writes("midrst", vecs[1].idx);

    // every pixel matches cb[5] exactly
    load_cb(0);
    load_px({4{24'h141414}});
    start();
    wait_done(cyc);
    chk("exact_cycles", cyc, EE_CYC);
    chk_writes("exact", {4{6'd5}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
